// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch sequencer.
// The ROM word layout is format[8], opcode[7:4], sign[3], operand[2:0].
package fetch_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        DRAIN  = 2'd2,
        HALTED = 2'd3
    } fetch_state_e;

    localparam int FMT_BIT  = 8;
    localparam int OPC_MSB  = 7;
    localparam int OPC_LSB  = 4;
    localparam int SIGN_BIT = 3;
    localparam int OPND_MSB = 2;

    localparam logic [8:0] HALT_WORD_DEFAULT = 9'h1FF;

    // True when a fetched word is the HALT encoding.
    function automatic logic is_halt_word(input logic [8:0] word, input logic [8:0] halt_word);
        return (word == halt_word);
    endfunction

endpackage

// File: rtl/fetch_out_reg.sv
// Holding register for the fetched instruction presented to decode.
// Priority: flush > load > consume. Flush and consume only drop the valid
// flag; the stale word/pc stay on the outputs until the next load.
module fetch_out_reg #(
    parameter int PC_W    = 16,
    parameter int INSTR_W = 9
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               load_i,
    input  logic               consume_i,
    input  logic               flush_i,
    input  logic [INSTR_W-1:0] word_i,
    input  logic [PC_W-1:0]    pc_i,
    output logic               valid_o,
    output logic [INSTR_W-1:0] word_o,
    output logic [PC_W-1:0]    pc_o
);

    logic               valid_q;
    logic [INSTR_W-1:0] word_q;
    logic [PC_W-1:0]    pc_q;

    // Update the held instruction according to flush/load/consume priority.
    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q <= 1'b0;
            word_q  <= '0;
            pc_q    <= '0;
        end else if (flush_i) begin
            valid_q <= 1'b0;
        end else if (load_i) begin
            valid_q <= 1'b1;
            word_q  <= word_i;
            pc_q    <= pc_i;
        end else if (consume_i) begin
            valid_q <= 1'b0;
        end else begin
            valid_q <= valid_q;
        end
    end

    assign valid_o = valid_q;
    assign word_o  = word_q;
    assign pc_o    = pc_q;

endmodule

// File: rtl/fetch_sequencer.sv
// Fetch sequencer: owns the PC, reads the combinational instruction ROM,
// and hands registered words to decode over valid/ready. Redirects from
// execute flush the held word and restart fetching at the target.
// Optional build macro FETCH_PERF_EN adds capture/flush counters.
module fetch_sequencer
    import fetch_pkg::*;
#(
    parameter int                PC_W      = 16,
    parameter int                INSTR_W   = 9,
    parameter logic [PC_W-1:0]   START_PC  = 16'd0,
    parameter logic [PC_W-1:0]   LAST_PC   = 16'd62,
    parameter logic [INSTR_W-1:0] HALT_WORD = HALT_WORD_DEFAULT
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    output logic [PC_W-1:0]    pc_out,
    input  logic [INSTR_W-1:0] rom_instr,
    output logic               instr_valid,
    input  logic               instr_ready,
    output logic [INSTR_W-1:0] instr_word,
    output logic [PC_W-1:0]    instr_pc,
    input  logic               redir_valid,
    input  logic [PC_W-1:0]    redir_pc,
    output logic               busy,
    output logic               done
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0]        perf_fetched,
    output logic [15:0]        perf_flushed
`endif
);

    localparam logic [PC_W-1:0] PC_ONE = {{(PC_W-1){1'b0}}, 1'b1};

    fetch_state_e    state_q, state_d;
    logic [PC_W-1:0] pc_q, pc_d;
    logic            done_q;
    logic            busy_q;
    logic            load_s;
    logic            consume_s;
    logic            flush_s;
    logic            start_take_s;
    logic            ends_prog_s;

    // The captured word ends the program if it is HALT or sits at LAST_PC.
    assign ends_prog_s = is_halt_word(rom_instr, HALT_WORD) || (pc_q == LAST_PC);

    // Next-state, next-PC and holding-register controls.
    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        load_s       = 1'b0;
        consume_s    = 1'b0;
        flush_s      = 1'b0;
        start_take_s = 1'b0;
        case (state_q)
            IDLE, HALTED: begin
                // Redirects are ignored here; start wins over a simultaneous redirect.
                if (start) begin
                    state_d      = RUN;
                    pc_d         = START_PC;
                    start_take_s = 1'b1;
                end else begin
                    state_d = state_q;
                end
            end
            RUN: begin
                if (redir_valid) begin
                    pc_d    = redir_pc;
                    flush_s = 1'b1;
                end else if (!instr_valid || instr_ready) begin
                    load_s = 1'b1;
                    pc_d   = pc_q + PC_ONE;
                    if (ends_prog_s) begin
                        state_d = DRAIN;
                    end else begin
                        state_d = RUN;
                    end
                end else begin
                    state_d = RUN;
                end
            end
            DRAIN: begin
                if (redir_valid) begin
                    pc_d    = redir_pc;
                    flush_s = 1'b1;
                    state_d = RUN;
                end else if (instr_valid && instr_ready) begin
                    consume_s = 1'b1;
                    state_d   = HALTED;
                end else begin
                    state_d = DRAIN;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // FSM state, PC and registered status outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            pc_q    <= START_PC;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            done_q  <= (state_d == HALTED) && (state_q != HALTED);
            busy_q  <= (state_d == RUN) || (state_d == DRAIN);
        end
    end

    fetch_out_reg #(
        .PC_W    (PC_W),
        .INSTR_W (INSTR_W)
    ) u_out_reg (
        .clk       (clk),
        .reset     (reset),
        .load_i    (load_s),
        .consume_i (consume_s),
        .flush_i   (flush_s),
        .word_i    (rom_instr),
        .pc_i      (pc_q),
        .valid_o   (instr_valid),
        .word_o    (instr_word),
        .pc_o      (instr_pc)
    );

    assign pc_out = pc_q;
    assign done   = done_q;
    assign busy   = busy_q;

`ifdef FETCH_PERF_EN
    logic [31:0] perf_fetched_q;
    logic [15:0] perf_flushed_q;

    // Saturating capture and wrong-path-flush counters, cleared on reset/start.
    always_ff @(posedge clk) begin
        if (reset || start_take_s) begin
            perf_fetched_q <= 32'd0;
            perf_flushed_q <= 16'd0;
        end else begin
            if (load_s && (perf_fetched_q != 32'hFFFF_FFFF)) begin
                perf_fetched_q <= perf_fetched_q + 32'd1;
            end else begin
                perf_fetched_q <= perf_fetched_q;
            end
            if (flush_s && instr_valid && (perf_flushed_q != 16'hFFFF)) begin
                perf_flushed_q <= perf_flushed_q + 16'd1;
            end else begin
                perf_flushed_q <= perf_flushed_q;
            end
        end
    end

    assign perf_fetched = perf_fetched_q;
    assign perf_flushed = perf_flushed_q;
`endif

endmodule

// File: tb/tb_fetch_sequencer.sv
// Self-checking bench for fetch_sequencer: directed scenarios followed by
// randomized stimulus, all compared cycle by cycle against a reference model.
module tb_fetch_sequencer;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic [15:0] pc_out;
    logic [8:0]  rom_instr;
    logic        instr_valid;
    logic        instr_ready = 1'b0;
    logic [8:0]  instr_word;
    logic [15:0] instr_pc;
    logic        redir_valid = 1'b0;
    logic [15:0] redir_pc = 16'd0;
    logic        busy;
    logic        done;
`ifdef FETCH_PERF_EN
    logic [31:0] perf_fetched;
    logic [15:0] perf_flushed;
`endif

    logic [8:0] rom [0:63];
    assign rom_instr = rom[pc_out[5:0]];

    fetch_sequencer dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .pc_out      (pc_out),
        .rom_instr   (rom_instr),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .instr_word  (instr_word),
        .instr_pc    (instr_pc),
        .redir_valid (redir_valid),
        .redir_pc    (redir_pc),
        .busy        (busy),
        .done        (done)
`ifdef FETCH_PERF_EN
        ,
        .perf_fetched(perf_fetched),
        .perf_flushed(perf_flushed)
`endif
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;
    int done_cnt = 0;

    // Reference model: "active" means a program is in flight (fetching or
    // waiting for the last word to leave); "fetching" means new words are read.
    logic        m_active;
    logic        m_fetching;
    logic [15:0] m_pc;
    logic        m_valid;
    logic [8:0]  m_word;
    logic [15:0] m_ipc;
    logic        m_done;
    longint      m_fetched;
    longint      m_flushed;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_update(input logic st, input logic rdy, input logic rv,
                                input logic [15:0] rpc, input logic rst);
        logic [8:0] w;
        if (rst) begin
            m_active = 1'b0; m_fetching = 1'b0; m_pc = 16'd0;
            m_valid = 1'b0; m_word = 9'd0; m_ipc = 16'd0; m_done = 1'b0;
            m_fetched = 0; m_flushed = 0;
        end else begin
            m_done = 1'b0;
            if (!m_active) begin
                if (st) begin
                    m_active = 1'b1; m_fetching = 1'b1; m_pc = 16'd0;
                    m_fetched = 0; m_flushed = 0;
                end
            end else if (rv) begin
                if (m_valid) m_flushed++;
                m_valid = 1'b0;
                m_pc = rpc;
                m_fetching = 1'b1;
            end else if (m_fetching) begin
                if (!m_valid || rdy) begin
                    w = rom[m_pc[5:0]];
                    m_word = w; m_ipc = m_pc; m_valid = 1'b1;
                    m_fetched++;
                    if (w == 9'h1FF || m_pc == 16'd62) m_fetching = 1'b0;
                    m_pc = m_pc + 16'd1;
                end
            end else begin
                if (m_valid && rdy) begin
                    m_valid = 1'b0; m_active = 1'b0; m_done = 1'b1;
                end
            end
        end
    endtask

    task automatic compare_all();
        check("pc_out", {16'd0, pc_out}, {16'd0, m_pc});
        check("instr_valid", {31'd0, instr_valid}, {31'd0, m_valid});
        check("instr_word", {23'd0, instr_word}, {23'd0, m_word});
        check("instr_pc", {16'd0, instr_pc}, {16'd0, m_ipc});
        check("busy", {31'd0, busy}, {31'd0, m_active});
        check("done", {31'd0, done}, {31'd0, m_done});
`ifdef FETCH_PERF_EN
        check("perf_fetched", perf_fetched, (m_fetched > 64'hFFFF_FFFF) ? 32'hFFFF_FFFF : m_fetched[31:0]);
        check("perf_flushed", {16'd0, perf_flushed}, {16'd0, (m_flushed > 64'hFFFF) ? 16'hFFFF : m_flushed[15:0]});
`endif
    endtask

    task automatic step(input logic st, input logic rdy, input logic rv,
                        input logic [15:0] rpc, input logic rst);
        start = st; instr_ready = rdy; redir_valid = rv; redir_pc = rpc; reset = rst;
        @(posedge clk);
        model_update(st, rdy, rv, rpc, rst);
        #1;
        compare_all();
        if (done === 1'b1) done_cnt++;
    endtask

    // Run with ready=1 until the model holds the word fetched from 'target'.
    task automatic run_until_ipc(input string tag, input logic [15:0] target, input int max_cycles);
        logic reached;
        reached = 1'b0;
        for (int i = 0; i < max_cycles; i++) begin
            if (m_valid && m_ipc == target) begin
                reached = 1'b1;
                break;
            end
            step(1'b0, 1'b1, 1'b0, 16'd0, 1'b0);
        end
        check(tag, {31'd0, reached}, 32'd1);
    endtask

    initial begin
        for (int i = 0; i < 64; i++) rom[i] = i[8:0];

        // Reset held two cycles, then idle with start low.
        step(1'b0, 1'b0, 1'b0, 16'd0, 1'b1);
        step(1'b0, 1'b0, 1'b0, 16'd0, 1'b1);
        step(1'b0, 1'b0, 1'b0, 16'd0, 1'b0);
        check("idle_pc", {16'd0, pc_out}, 32'd0);

        // Start and stream; stall on word @5.
        step(1'b1, 1'b1, 1'b0, 16'd0, 1'b0);
        run_until_ipc("wait_ipc5", 16'd5, 20);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b0, 16'd0, 1'b0);
        check("stall_ipc", {16'd0, instr_pc}, 32'd5);
        check("stall_pc", {16'd0, pc_out}, 32'd6);
        step(1'b0, 1'b1, 1'b0, 16'd0, 1'b0);
        check("after_stall_ipc", {16'd0, instr_pc}, 32'd6);

        // Redirect to 40 while word @12 is valid.
        run_until_ipc("wait_ipc12", 16'd12, 20);
        step(1'b0, 1'b1, 1'b1, 16'd40, 1'b0);
        check("redir_valid0", {31'd0, instr_valid}, 32'd0);
        check("redir_pc40", {16'd0, pc_out}, 32'd40);
        step(1'b0, 1'b1, 1'b0, 16'd0, 1'b0);
        check("redir_ipc40", {16'd0, instr_pc}, 32'd40);

        // Run to the end of the program; done pulses once.
        for (int i = 0; i < 60 && done_cnt == 0; i++) step(1'b0, 1'b1, 1'b0, 16'd0, 1'b0);
        for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 1'b0, 16'd0, 1'b0);
        check("done_pulses", done_cnt, 32'd1);

        // HALT word at 7, then redirect out of DRAIN back to 3.
        rom[7] = 9'h1FF;
        step(1'b1, 1'b1, 1'b0, 16'd0, 1'b0);
        run_until_ipc("wait_ipc7", 16'd7, 20);
        step(1'b0, 1'b0, 1'b0, 16'd0, 1'b0);
        check("halt_pc_frozen", {16'd0, pc_out}, 32'd8);
        check("halt_word", {23'd0, instr_word}, 32'h1FF);
        step(1'b0, 1'b0, 1'b1, 16'd3, 1'b0);
        check("drain_redir_pc", {16'd0, pc_out}, 32'd3);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b0, 16'd0, 1'b0);
        check("no_done_after_redir", done_cnt, 32'd1);

        // Reset mid-run with a stalled valid word.
        step(1'b0, 1'b0, 1'b0, 16'd0, 1'b0);
        step(1'b0, 1'b0, 1'b0, 16'd0, 1'b1);
        check("rst_valid", {31'd0, instr_valid}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);

        // Five captures after a fresh start.
        step(1'b0, 1'b0, 1'b0, 16'd0, 1'b0);
        step(1'b1, 1'b0, 1'b0, 16'd0, 1'b0);
        for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 1'b0, 16'd0, 1'b0);
        check("five_captures_ipc", {16'd0, instr_pc}, 32'd4);

        // Randomized program contents and handshake/redirect/start/reset traffic.
        for (int i = 0; i < 64; i++) rom[i] = ($urandom_range(0, 9) == 0) ? 9'h1FF : 9'($urandom_range(0, 510));
        for (int i = 0; i < 3000; i++) begin
            step(($urandom_range(0, 15) == 0),
                 ($urandom_range(0, 3) != 0),
                 ($urandom_range(0, 19) == 0),
                 16'($urandom_range(0, 62)),
                 ($urandom_range(0, 199) == 0));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
